// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies and FSM states.
// The decoder/stall logic imports this too so everyone agrees on encodings.
package mdu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MADD  = 4'd5;
    localparam logic [OP_W-1:0] OP_MADDU = 4'd6;
    localparam logic [OP_W-1:0] OP_MSUB  = 4'd7;
    localparam logic [OP_W-1:0] OP_MSUBU = 4'd8;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd9;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd10;

    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_mult_class(input logic [OP_W-1:0] op);
        return (op == OP_MULT)  || (op == OP_MULTU) ||
               (op == OP_MADD)  || (op == OP_MADDU) ||
               (op == OP_MSUB)  || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle of the request/result signals between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
    import mdu_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     A;
    logic [31:0]     B;
    logic            busy;
    logic [31:0]     HI;
    logic [31:0]     LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);

endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed at accept, held pending, and committed
// to HI/LO after a fixed busy latency so the pipeline sees a MIPS-like multi-cycle unit.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     A,
    input  logic [31:0]     B,
    output logic            busy,
    output logic [31:0]     HI,
    output logic [31:0]     LO
);

    state_t      state, next_state;
    logic [3:0]  cnt, next_cnt;
    logic [63:0] pending, next_pending;
    logic        pending_valid, next_pending_valid;
    logic [31:0] next_hi, next_lo;

    logic [63:0] hilo, prod_s, prod_u, mul_res;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, quo_mag, rem_mag, quo, rem;

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        hilo    = {HI, LO};
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
        mul_res = prod_s;
        case (op)
            OP_MULTU: mul_res = prod_u;
            OP_MADD:  mul_res = hilo + prod_s;
            OP_MADDU: mul_res = hilo + prod_u;
            OP_MSUB:  mul_res = hilo - prod_s;
            OP_MSUBU: mul_res = hilo - prod_u;
            default:  mul_res = prod_s;
        endcase

        neg_a   = (op == OP_DIV) && A[31];
        neg_b   = (op == OP_DIV) && B[31];
        mag_a   = neg_a ? -A : A;
        mag_b   = neg_b ? -B : B;
        div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quo_mag = mag_a / div_b;
        rem_mag = mag_a % div_b;
        quo     = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
        rem     = neg_a ? -rem_mag : rem_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            pending       <= 64'd0;
            pending_valid <= 1'b0;
            HI            <= 32'd0;
            LO            <= 32'd0;
        end else begin
            state         <= next_state;
            cnt           <= next_cnt;
            pending       <= next_pending;
            pending_valid <= next_pending_valid;
            HI            <= next_hi;
            LO            <= next_lo;
        end
    end

    // Divide by zero still occupies the unit for the full latency, but never commits.
    always_comb begin
        next_state         = state;
        next_cnt           = cnt;
        next_pending       = pending;
        next_pending_valid = pending_valid;
        next_hi            = HI;
        next_lo            = LO;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult_class(op)) begin
                        next_state         = ST_MUL;
                        next_cnt           = MULT_LAT;
                        next_pending       = mul_res;
                        next_pending_valid = 1'b1;
                    end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
                        next_state         = ST_DIV;
                        next_cnt           = DIV_LAT;
                        next_pending       = {rem, quo};
                        next_pending_valid = (B != 32'd0);
                    end else if (op == OP_MTHI) begin
                        next_hi = A;
                    end else if (op == OP_MTLO) begin
                        next_lo = A;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                next_cnt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    next_state = ST_IDLE;
                    if (pending_valid) begin
                        {next_hi, next_lo} = pending;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO and busy length,
// a negedge monitor checks them when busy falls.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    bit   prev_busy;
    int   busy_run;

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .start (bus.start),
        .op    (bus.op),
        .A     (bus.A),
        .B     (bus.B),
        .busy  (bus.busy),
        .HI    (bus.HI),
        .LO    (bus.LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op at a negedge; ops with a latency queue their expected outcome first.
    task automatic applyStimulus(input string name, input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int cycles,
                                 input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        @(negedge clk);
        if (cycles > 0) begin
            e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cycles;
            exp_q.push_back(e);
        end
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_NONE;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        checkOutput({name, "_timeout"}, {31'd0, bus.busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_run  = 0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got result HI=0x%08h LO=0x%08h expected none", bus.HI, bus.LO);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput({e.name, "_hi"}, bus.HI, e.hi);
                    checkOutput({e.name, "_lo"}, bus.LO, e.lo);
                    checkOutput({e.name, "_busy_cycles"}, busy_run, e.cycles);
                end
                busy_run = 0;
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; errors = 0;
        prev_busy = 1'b0; busy_run = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = OP_NONE; bus.A = 32'd0; bus.B = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_hi", bus.HI, 32'd0);
        checkOutput("reset_lo", bus.LO, 32'd0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        checkOutput("first_accept_busy", {31'd0, bus.busy}, 32'd1);
        waitIdle("mult");
        applyStimulus("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'd1, 32'hFFFFFFFE);
        waitIdle("multu");
        applyStimulus("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        waitIdle("div_neg");
        applyStimulus("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        waitIdle("divu");

        applyStimulus("mtlo", OP_MTLO, 32'd10, 32'd0, 0, 32'd0, 32'd0);
        checkOutput("mtlo_lo", bus.LO, 32'd10);
        checkOutput("mtlo_hi_kept", bus.HI, 32'd1);
        checkOutput("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        applyStimulus("mthi", OP_MTHI, 32'd0, 32'd0, 0, 32'd0, 32'd0);
        checkOutput("mthi_hi", bus.HI, 32'd0);
        checkOutput("mthi_lo_kept", bus.LO, 32'd10);

        applyStimulus("msub", OP_MSUB, 32'd3, 32'd4, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        waitIdle("msub");
        applyStimulus("madd", OP_MADD, 32'd3, 32'd4, 5, 32'd0, 32'd10);
        waitIdle("madd");

        applyStimulus("mthi5", OP_MTHI, 32'd5, 32'd0, 0, 32'd0, 32'd0);
        applyStimulus("mtlo6", OP_MTLO, 32'd6, 32'd0, 0, 32'd0, 32'd0);
        checkOutput("preset_hi", bus.HI, 32'd5);
        checkOutput("preset_lo", bus.LO, 32'd6);
        applyStimulus("div_by_zero", OP_DIV, 32'd123, 32'd0, 10, 32'd5, 32'd6);
        waitIdle("div_by_zero");
        applyStimulus("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        waitIdle("div_ovf");

        applyStimulus("mult_busy", OP_MULT, 32'h00010000, 32'h00030000, 5, 32'd3, 32'd0);
        applyStimulus("mthi_ignored", OP_MTHI, 32'h00001234, 32'd0, 0, 32'd0, 32'd0);
        checkOutput("ignored_hi", bus.HI, 32'd0);
        checkOutput("ignored_busy", {31'd0, bus.busy}, 32'd1);
        waitIdle("mult_busy");

        applyStimulus("maddu", OP_MADDU, 32'hFFFFFFFF, 32'd2, 5, 32'd4, 32'hFFFFFFFE);
        waitIdle("maddu");
        applyStimulus("msubu", OP_MSUBU, 32'd1, 32'hFFFFFFFF, 5, 32'd3, 32'hFFFFFFFF);
        waitIdle("msubu");
        applyStimulus("noop", 4'd11, 32'hDEAD, 32'hBEEF, 0, 32'd0, 32'd0);
        checkOutput("noop_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("noop_hi", bus.HI, 32'd3);
        checkOutput("noop_lo", bus.LO, 32'hFFFFFFFF);

        // Abort a divide at busy cycle 4; the discarded result must never show up.
        applyStimulus("div_abort", OP_DIVU, 32'd100, 32'd3, 0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_hi", bus.HI, 32'd0);
        checkOutput("abort_lo", bus.LO, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.start = 1'b1; bus.op = OP_MTLO; bus.A = 32'd1; bus.B = 32'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_NONE;
        checkOutput("post_reset_mtlo_lo", bus.LO, 32'd1);
        checkOutput("post_reset_mtlo_hi", bus.HI, 32'd0);
        checkOutput("post_reset_busy", {31'd0, bus.busy}, 32'd0);

        repeat (15) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to execute op.
REQ-004 SHALL have port op, input, 4 bits: operation code per REQ-010.
REQ-005 SHALL have port A, input, 32 bits: rs operand (forwarded RD1_E).
REQ-006 SHALL have port B, input, 32 bits: rt operand (forwarded RD2_E).
REQ-007 SHALL have port busy, output, 1 bit: multi-cycle operation in progress.
REQ-008 SHALL have port HI, output, 32 bits: HI register, read directly by mfhi.
REQ-009 SHALL have port LO, output, 32 bits: LO register, read directly by mflo.

Function
REQ-010 SHALL decode op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; codes 11-15 are no-ops.
REQ-011 SHALL accept start only at an edge where busy=0; start with busy=1 is ignored, with no state change.
REQ-012 SHALL implement an FSM with states IDLE, MUL and DIV and a 4-bit down-counter.
REQ-013 On an accepted MULT-class op (1, 2, 5-8): SHALL latch the full 64-bit result, enter MUL with counter=5, and raise busy from the next cycle.
REQ-014 On an accepted DIV/DIVU: SHALL latch quotient and remainder, enter DIV with counter=10, and raise busy from the next cycle.
REQ-015 SHALL decrement the counter each cycle in MUL/DIV; on the edge leaving counter=1 it SHALL write HI/LO, return to IDLE and drop busy.
REQ-016 busy SHALL be high for exactly 5 cycles (mult-class) or 10 cycles (div-class); the new HI/LO SHALL be visible in the first cycle with busy=0.
REQ-017 MULT/MULTU SHALL compute {HI,LO}=A*B, signed/unsigned 64-bit.
REQ-018 MADD(U)/MSUB(U) SHALL compute {HI,LO}={HI,LO}+/-A*B, modulo 2^64, using HI/LO as sampled at the accept edge.
REQ-019 DIV SHALL truncate the quotient toward zero into LO; the remainder, carrying the dividend's sign, SHALL go to HI; DIVU SHALL be unsigned.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-021 Divide by zero (B=0) SHALL run the full 10 busy cycles and leave HI/LO unchanged.
REQ-022 MTHI/MTLO accepted SHALL write A to HI/LO at that edge; busy SHALL stay 0; the other register SHALL be unchanged.
REQ-023 HI/LO SHALL change only as specified in REQ-015 and REQ-022.

Reset
REQ-024 reset low SHALL immediately force HI=0, LO=0, busy=0, state IDLE and counter=0, including mid-operation; the aborted result is discarded.
REQ-025 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-026 Op codes, MULT_LAT=5, DIV_LAT=10 and the FSM state encoding SHALL live in shared package mdu_pkg, also used by the decoder/stall logic.
REQ-027 SHALL be a single module with no sub-modules; results are computed combinationally at accept and held in a 64-bit pending register.

Verification
REQ-028 MULT A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-029 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-030 MTLO A=10, MTHI A=0, then MSUB A=3, B=4 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MADD A=3, B=4 afterwards -> HI=0, LO=10.
REQ-031 HI=5, LO=6 then DIV B=0 -> busy 10 cycles, HI=5, LO=6 unchanged; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-032 MULT accepted, then start MTHI A=0x1234 at busy cycle 2 -> ignored; the final HI equals the product high word, not 0x1234.
REQ-033 reset low at busy cycle 4 of a DIV -> busy=0, HI=LO=0 immediately; after release, MTLO A=1 -> LO=1 at the next edge.
